// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the init-clearing SRAM array
package sram_pkg;

  typedef enum logic {
    FSM_INIT = 1'b0,
    FSM_RUN  = 1'b1
  } sram_fsm_e;

  localparam int READ_LAT_MAX = 2;

  // Request bundle geometry of the default array configuration.
  localparam int REQ_ADDR_W = 9;
  localparam int REQ_SEGS   = 8;
  localparam int REQ_SEG_W  = 19;

  typedef struct packed {
    logic                            write;
    logic [REQ_ADDR_W-1:0]           addr;
    logic [REQ_SEGS-1:0]             wmask;
    logic [REQ_SEGS*REQ_SEG_W-1:0]   wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_sp_core.sv
// rtl/sram_sp_core.sv - plain single-port storage with segment-masked write, no reset
module sram_sp_core #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9,
  parameter int SEGS   = 8,
  parameter int SEG_W  = 19
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [ADDR_W-1:0]       addr_i,
  input  logic [SEGS-1:0]         wmask_i,
  input  logic [SEGS*SEG_W-1:0]   wdata_i,
  output logic [SEGS*SEG_W-1:0]   rdata_o
);

  localparam int DATA_W = SEGS * SEG_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Masked segment write; read data is sampled and held until the next read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < SEGS; i++) begin
        if (wmask_i[i]) begin
          mem_q[addr_i][i*SEG_W +: SEG_W] <= wdata_i[i*SEG_W +: SEG_W];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_sp_init_array.sv
// rtl/sram_sp_init_array.sv - masked-write SRAM array that self-clears after reset
module sram_sp_init_array
  import sram_pkg::*;
#(
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 9,
  parameter int SEG_W      = 19,
  parameter int SEGS       = 8,
  parameter int READ_LAT   = 1,
  parameter int HOLD_RDATA = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [SEGS-1:0]         req_wmask,
  input  logic [SEGS*SEG_W-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [SEGS*SEG_W-1:0]   resp_rdata,
  output logic                    init_done
);

  localparam int DATA_W = SEGS * SEG_W;
  // One extra bit so the counter can reach DEPTH when DEPTH is 2**ADDR_W.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam int LAT = (READ_LAT >= READ_LAT_MAX) ? READ_LAT_MAX : 1;

  sram_fsm_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               init_wr, accept, in_range;
  logic               core_we, core_re;
  logic [ADDR_W-1:0]  core_addr;
  logic [SEGS-1:0]    core_wmask;
  logic [DATA_W-1:0]  core_wdata, core_rdata;
  logic               v1_q, oor1_q;
  logic [DATA_W-1:0]  data1;
  logic               pipe_valid;
  logic [DATA_W-1:0]  pipe_data;

  // State register and init counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FSM_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Walk every entry once, then spend one more edge leaving INIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == FSM_INIT) begin
      if (cnt_q == DEPTH_C) begin
        state_d = FSM_RUN;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Handshake and core port steering: init writes win over requests.
  always_comb begin
    req_ready  = (state_q == FSM_RUN);
    init_done  = (state_q == FSM_RUN);
    init_wr    = (state_q == FSM_INIT) && (cnt_q != DEPTH_C);
    accept     = (state_q == FSM_RUN) && req_valid;
    in_range   = ({1'b0, req_addr} < DEPTH_C);
    core_we    = init_wr || (accept && req_write && in_range);
    core_re    = accept && !req_write && in_range;
    core_addr  = init_wr ? cnt_q[ADDR_W-1:0] : req_addr;
    core_wmask = init_wr ? '1 : req_wmask;
    core_wdata = init_wr ? '0 : req_wdata;
  end

  sram_sp_core #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .SEGS   (SEGS),
    .SEG_W  (SEG_W)
  ) u_core (
    .clk_i   (clock),
    .we_i    (core_we),
    .re_i    (core_re),
    .addr_i  (core_addr),
    .wmask_i (core_wmask),
    .wdata_i (core_wdata),
    .rdata_o (core_rdata)
  );

  // First response stage: remember that a read was taken and whether it missed the array.
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q   <= 1'b0;
      oor1_q <= 1'b0;
    end else begin
      v1_q   <= accept && !req_write;
      oor1_q <= !in_range;
    end
  end

  assign data1 = oor1_q ? '0 : core_rdata;

  if (LAT == READ_LAT_MAX) begin : g_lat2
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    // Extra output register; the data is captured so later writes cannot disturb it.
    always_ff @(posedge clock) begin
      if (reset) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          d2_q <= data1;
        end
      end
    end

    assign pipe_valid = v2_q;
    assign pipe_data  = d2_q;
  end else begin : g_lat1
    assign pipe_valid = v1_q;
    assign pipe_data  = data1;
  end

  if (HOLD_RDATA != 0) begin : g_hold
    logic [DATA_W-1:0] hold_q;

    // Keep the last response visible between responses.
    always_ff @(posedge clock) begin
      if (reset) begin
        hold_q <= '0;
      end else if (pipe_valid) begin
        hold_q <= pipe_data;
      end
    end

    assign resp_rdata = pipe_valid ? pipe_data : hold_q;
  end else begin : g_nohold
    assign resp_rdata = pipe_valid ? pipe_data : '0;
  end

  assign resp_valid = pipe_valid;

endmodule

// File: tb/tb_sram_sp_init_array.sv
// tb/tb_sram_sp_init_array.sv - scoreboard bench for two array configurations
module tb_sram_sp_init_array;
  import sram_pkg::*;

  localparam int DW      = 152;
  localparam int DEPTH_A = 512;
  localparam int DEPTH_B = 300;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [8:0]    req_addr = '0;
  logic [7:0]    req_wmask = '0;
  logic [DW-1:0] req_wdata = '0;

  logic          a_ready, a_valid, a_done;
  logic [DW-1:0] a_rdata;
  logic          b_ready, b_valid, b_done;
  logic [DW-1:0] b_rdata;

  sram_sp_init_array #(.DEPTH(DEPTH_A), .ADDR_W(9), .SEG_W(19), .SEGS(8),
                       .READ_LAT(1), .HOLD_RDATA(1)) dut_a (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wmask(req_wmask),
    .req_wdata(req_wdata), .resp_valid(a_valid), .resp_rdata(a_rdata),
    .init_done(a_done));

  sram_sp_init_array #(.DEPTH(DEPTH_B), .ADDR_W(9), .SEG_W(19), .SEGS(8),
                       .READ_LAT(2), .HOLD_RDATA(0)) dut_b (
    .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wmask(req_wmask),
    .req_wdata(req_wdata), .resp_valid(b_valid), .resp_rdata(b_rdata),
    .init_done(b_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] ma [DEPTH_A];
  logic [DW-1:0] mb [DEPTH_B];
  logic [DW-1:0] last_a = '0;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
    return t[DW-1:0];
  endfunction

  function automatic sram_req_t mk(input logic w, input int addr, input logic [7:0] m,
                                   input logic [DW-1:0] d);
    sram_req_t r;
    r.write = w;
    r.addr  = 9'(addr);
    r.wmask = m;
    r.wdata = d;
    return r;
  endfunction

  // Reference model: storage as plain arrays, reads answered LAT edges after acceptance.
  task automatic model(input sram_req_t r);
    exp_t e;
    int   a = int'(r.addr);
    if (r.write) begin
      for (int i = 0; i < 8; i++) begin
        if (r.wmask[i]) begin
          if (a < DEPTH_A) ma[a][i*19 +: 19] = r.wdata[i*19 +: 19];
          if (a < DEPTH_B) mb[a][i*19 +: 19] = r.wdata[i*19 +: 19];
        end
      end
    end else begin
      e.data = (a < DEPTH_A) ? ma[a] : '0;
      e.cyc  = cyc + 1;
      qa.push_back(e);
      e.data = (a < DEPTH_B) ? mb[a] : '0;
      e.cyc  = cyc + 2;
      qb.push_back(e);
    end
  endtask

  task automatic issue(input sram_req_t r);
    req_valid = 1'b1;
    req_write = r.write;
    req_addr  = r.addr;
    req_wmask = r.wmask;
    req_wdata = r.wdata;
    model(r);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Assert reset for one edge, check reset state, then time the clearing walk.
  task automatic do_reset();
    int first_a, first_b, bad_a, bad_b;
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    qa.delete();
    qb.delete();
    foreach (ma[i]) ma[i] = '0;
    foreach (mb[i]) mb[i] = '0;
    last_a = '0;
    check("rst_a_ready", a_ready, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_ready", b_ready, 0);
    check("rst_b_done", b_done, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_b_rdata", b_rdata, 0);
    reset = 1'b0;
    first_a = -1; first_b = -1; bad_a = 0; bad_b = 0;
    for (int k = 0; k <= DEPTH_A + 8; k++) begin
      @(posedge clk); #1;
      if (first_a < 0 && a_done === 1'b1) first_a = k;
      if (first_b < 0 && b_done === 1'b1) first_b = k;
      if (a_ready !== a_done || (first_a >= 0 && a_done !== 1'b1)) bad_a++;
      if (b_ready !== b_done || (first_b >= 0 && b_done !== 1'b1)) bad_b++;
    end
    check("init_edges_a", first_a, DEPTH_A);
    check("init_edges_b", first_b, DEPTH_B);
    check("ready_vs_done_a", bad_a, 0);
    check("ready_vs_done_b", bad_b, 0);
  endtask

  // Monitor for the latency-1, holding configuration.
  always @(negedge clk) begin
    exp_t e;
    if (a_valid === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_resp_without_read", a_valid, 0);
      end else begin
        e = qa.pop_front();
        check("a_rdata", a_rdata, e.data);
        check("a_latency", cyc, e.cyc);
        last_a = e.data;
      end
    end else begin
      check("a_hold", a_rdata, last_a);
    end
  end

  // Monitor for the latency-2, non-holding configuration.
  always @(negedge clk) begin
    exp_t e;
    if (b_valid === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_resp_without_read", b_valid, 0);
      end else begin
        e = qb.pop_front();
        check("b_rdata", b_rdata, e.data);
        check("b_latency", cyc, e.cyc);
      end
    end else begin
      check("b_idle_zero", b_rdata, 0);
    end
  end

  initial begin
    logic [DW-1:0] ones;
    ones = '1;
    do_reset();

    issue(mk(1'b0, 0, 8'h00, '0));
    issue(mk(1'b0, 255, 8'h00, '0));
    issue(mk(1'b0, 511, 8'h00, '0));
    idle(3);

    issue(mk(1'b1, 7, 8'hFF, ones));
    issue(mk(1'b1, 7, 8'h05, '0));
    issue(mk(1'b0, 7, 8'h00, '0));
    idle(2);

    issue(mk(1'b1, 10, 8'hFF, DW'(1)));
    issue(mk(1'b1, 11, 8'hFF, DW'(2)));
    issue(mk(1'b1, 12, 8'hFF, DW'(3)));
    issue(mk(1'b0, 10, 8'h00, '0));
    issue(mk(1'b0, 11, 8'h00, '0));
    issue(mk(1'b0, 12, 8'h00, '0));
    idle(10);

    issue(mk(1'b1, 400, 8'hFF, rnd_data()));
    issue(mk(1'b0, 400, 8'h00, '0));
    issue(mk(1'b1, 299, 8'hFF, rnd_data()));
    issue(mk(1'b0, 299, 8'h00, '0));
    issue(mk(1'b1, 20, 8'hFF, rnd_data()));
    issue(mk(1'b0, 20, 8'h00, '0));
    issue(mk(1'b1, 20, 8'h3C, rnd_data()));
    issue(mk(1'b0, 20, 8'h00, '0));
    idle(4);

    for (int n = 0; n < 400; n++) begin
      int a;
      a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 511));
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(mk(1'($urandom_range(0, 1)), a, 8'($urandom), rnd_data()));
    end
    idle(10);

    issue(mk(1'b1, 5, 8'hFF, DW'(8'hAB)));
    issue(mk(1'b0, 5, 8'h00, '0));
    do_reset();
    check("post_reset_no_resp_a", a_valid, 0);
    check("post_reset_no_resp_b", b_valid, 0);
    issue(mk(1'b0, 5, 8'h00, '0));
    idle(5);

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_sp_init_array.md
# sram_sp_init_array

Parametrised single-port masked-write SRAM array with a self-clearing init engine, a valid/ready request interface, and configurable read latency with optional read-data hold. It is the next generation of the per-cache-way data/tag array macros. Behavioural model and wrapper sit under the SRAM templates. Every entry reads as zero after reset, without firmware or the cache controller issuing clear writes.

## Interface
- `DEPTH`, 512: number of entries, ≥2, need not be a power of two.
- `ADDR_W`, 9: address width, ≥ ceil(log2(DEPTH)).
- `SEG_W`, 19: bits per mask segment.
- `SEGS`, 8: mask segments per entry; entry width is `SEGS*SEG_W`.
- `READ_LAT`, 1: request-to-response latency, 1 or 2.
- `HOLD_RDATA`, 1: 1 holds `resp_rdata` until the next read response; 0 drives zero when `resp_valid` is low.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the block accepts a request; low during init.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: entry index.
- `req_wmask` in `SEGS`: per-segment write enable.
- `req_wdata` in `SEGS*SEG_W`: write data.
- `resp_valid` out 1: one-cycle pulse, read data valid.
- `resp_rdata` out `SEGS*SEG_W`: read data.
- `init_done` out 1: high once clearing completes; stays high until the next reset.

## Operation
- FSM states are INIT and RUN. Reset forces INIT and sets the init counter to 0.
- In INIT:
  - Each cycle, write all-zero, full mask, to entry `cnt`, then `cnt++`.
  - After the write to `DEPTH-1`, go to RUN on the next edge.
  - `req_ready`=0; requests are ignored, not queued.
- In RUN, `req_ready`=1 and a request is accepted when `req_valid`=1.
- Write (`req_write`=1): for each i with `req_wmask[i]`=1, the segment `[i*SEG_W +: SEG_W]` of the entry updates at the accepting edge. Unmasked segments are unchanged. An all-zero mask is a no-op.
- Read (`req_write`=0):
  - The array is sampled at the accepting edge.
  - With `READ_LAT`=2, the sampled data passes through one extra output register.
- Out-of-range address (`req_addr` ≥ `DEPTH`):
  - A write is dropped.
  - A read still produces `resp_valid`, with all-zero data.
- Read-after-write to the same address in the next cycle returns the new data.
- A write issued while an earlier read is in flight (`READ_LAT`=2) does not affect that read's data.
- Reset mid-operation:
  - In-flight responses are discarded; `resp_valid` is 0 from the cycle after reset.
  - Init restarts from entry 0.
  - Array contents are fully cleared again.

## Timing
- Reset values:
  - `req_ready`=0, `init_done`=0, `resp_valid`=0.
  - `resp_rdata`=0.
  - FSM=INIT, `cnt`=0.
- Init takes exactly `DEPTH` cycles. `reset` is deasserted before edge 0 of those cycles. `init_done` and `req_ready` rise after edge `DEPTH`.
- A read accepted at edge N gives `resp_valid`=1 during cycle N+`READ_LAT`−1→N+`READ_LAT`, i.e. visible `READ_LAT` cycles after acceptance (1 = next cycle).
- Full throughput: one request per cycle; back-to-back reads give back-to-back responses.
- With `HOLD_RDATA`=1, `resp_rdata` changes only on a cycle where `resp_valid`=1.

## Structure
- Shared package `sram_pkg`:
  - `FSM_INIT`/`FSM_RUN` encoding.
  - `sram_req_t` (write, addr, wmask, wdata).
  - `READ_LAT_MAX`=2.
- One sub-module, `sram_sp_core`: a plain storage array with a masked write and a registered read sample, no reset. It can be swapped for a technology macro.
- The FSM, init counter, response pipeline and hold register stay in the top level.

## Test plan
- Reset then idle, `DEPTH`=512:
  - `req_ready`=0 for 512 cycles; `init_done` rises after cycle 512.
  - Reading addr 0, 255 and 511 returns 0.
- Masked write and read-back:
  - Write addr 7, `wdata`=all-ones, `wmask`=0xFF; then write addr 7, `wdata`=0, `wmask`=0x05.
  - Reading addr 7 returns all-ones except segments 0 and 2, which are zero.
- Latency, `READ_LAT`=1 and 2:
  - Issue reads to 3 consecutive addresses holding values 1, 2, 3 back to back.
  - Responses arrive on 3 consecutive cycles, 1 and 2 cycles after each request respectively.
- Hold behaviour:
  - `HOLD_RDATA`=1: `rdata` stays at the last value for 10 idle cycles.
  - `HOLD_RDATA`=0: `rdata`=0 whenever `resp_valid`=0.
- Reset mid-run:
  - Write addr 5 = 0xAB, issue a read, assert reset in the cycle after the read is accepted.
  - No `resp_valid` follows; after re-init, addr 5 reads 0.
- Boundary, `DEPTH`=300 with `ADDR_W`=9:
  - A write to addr 400 is dropped; a read of addr 400 returns 0 with `resp_valid`.
  - Addr 299 is writable and readable.
  - Init lasts 300 cycles.
